// File: rtl/isa_types.sv
// Shared ISA-level types for the hart: memory port control, opcodes and the
// prefetch entry carried from fetch to decode.
package isa_types;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [6:0] {
    OPCODE_LOAD   = 7'b0000011,
    OPCODE_OP_IMM = 7'b0010011,
    OPCODE_STORE  = 7'b0100011,
    OPCODE_OP     = 7'b0110011,
    OPCODE_BRANCH = 7'b1100011,
    OPCODE_JAL    = 7'b1101111
  } opcode_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      wwidth;
    logic            wenable;
  } mem_control_t;

  typedef struct packed {
    logic [ILEN-1:0] bits;
    logic [XLEN-1:0] pc;
    logic            is_load;
  } fetch_entry_t;

  typedef enum logic {
    IDLE,
    READ
  } fetch_state_t;

  function automatic logic is_load_opcode(input logic [ILEN-1:0] word);
    return word[6:0] == OPCODE_LOAD;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched instruction entries with a one-cycle flush.
// The head entry is read straight from storage, so consumers see registered data.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type fetch_entry_t = logic [31:0]
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  fetch_entry_t   storage [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CNTW'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = storage[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CNTW'(push) - CNTW'(do_pop);
    end
  end

  // Storage needs no reset: pointers alone decide what is visible.
  always_ff @(posedge clock) begin
    if (push) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_prefetcher.sv
// Fetch front end: streams sequential instruction words from the shared memory
// port into a FIFO for decode; a redirect flushes and restarts at the target.
module instruction_prefetcher
  import isa_types::*;
#(
  parameter int              DEPTH        = 2,
  parameter int              READ_LATENCY = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mem_grant,
  input  logic [XLEN-1:0]  mem_rdata,
  output mem_control_t     mem_ctrl,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             instr_ready,
  output logic             instr_valid,
  output logic [ILEN-1:0]  instr_bits,
  output logic [XLEN-1:0]  instr_pc,
  output logic             instr_is_load,
  output fetch_state_t     fetch_state
);

  // Handshake: an entry moves to decode on a cycle where instr_valid and
  // instr_ready are both high and no redirect is present; valid never waits on ready.

  localparam int CW   = $clog2(READ_LATENCY + 1);
  localparam int CNTW = $clog2(DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] read_addr;
  logic [CW-1:0]   remaining;
  logic            start_read;
  logic            capture;

  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNTW-1:0] fifo_count;

  always_comb begin
    state_d    = state_q;
    start_read = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_grant && (fifo_count < CNTW'(DEPTH)) && !redirect) begin
          state_d    = READ;
          start_read = 1'b1;
        end
      end
      READ: begin
        if (redirect || !mem_grant) begin
          state_d = IDLE;
        end else if (remaining == '0) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The issue cycle already presents the address, so it counts as the first
  // latency cycle and the counter starts one short.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      fetch_pc  <= RESET_VECTOR;
      read_addr <= RESET_VECTOR;
      remaining <= '0;
    end else begin
      state_q <= state_d;
      if (redirect) begin
        fetch_pc <= redirect_pc & ~XLEN'(3);
      end else if (capture) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (start_read) begin
        read_addr <= fetch_pc;
        remaining <= CW'(READ_LATENCY - 1);
      end else if (state_q == READ && remaining != '0) begin
        remaining <= remaining - CW'(1);
      end
    end
  end

  always_comb begin
    mem_ctrl         = '0;
    mem_ctrl.addr    = (state_q == READ) ? read_addr : fetch_pc;
    mem_ctrl.wenable = 1'b0;
  end

  always_comb begin
    push_entry         = '0;
    push_entry.bits    = mem_rdata[ILEN-1:0];
    push_entry.pc      = read_addr;
    push_entry.is_load = is_load_opcode(mem_rdata[ILEN-1:0]);
  end

  fetch_fifo #(
    .DEPTH         (DEPTH),
    .fetch_entry_t (fetch_entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (capture && !fifo_full),
    .push_data (push_entry),
    .pop       (instr_valid && instr_ready && !redirect),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign instr_valid   = !fifo_empty;
  assign instr_bits    = head.bits;
  assign instr_pc      = head.pc;
  assign instr_is_load = head.is_load;
  assign fetch_state   = state_q;

endmodule

// File: tb/tb_instruction_prefetcher.sv
// Self-checking bench for instruction_prefetcher: directed timing scenarios plus
// a randomized run checked against a sequential-PC reference model.
module tb_instruction_prefetcher;
  import isa_types::*;

  localparam int RL    = 2;
  localparam int DEPTH = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic         mem_grant;
  logic [31:0]  mem_rdata;
  mem_control_t mem_ctrl;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         instr_ready;
  logic         instr_valid;
  logic [31:0]  instr_bits;
  logic [31:0]  instr_pc;
  logic         instr_is_load;
  fetch_state_t fetch_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] mem [256];
  logic [31:0] addr_pipe [RL];
  logic [31:0] exp_q [$];

  always #5 clock = ~clock;

  // Memory model: data for an address appears RL cycles after it is presented.
  always @(posedge clock) begin
    addr_pipe[0] <= mem_ctrl.addr;
    for (int i = 1; i < RL; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign mem_rdata = mem[addr_pipe[RL-1][9:2]];

  instruction_prefetcher #(
    .DEPTH        (DEPTH),
    .READ_LATENCY (RL),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_grant     (mem_grant),
    .mem_rdata     (mem_rdata),
    .mem_ctrl      (mem_ctrl),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .instr_ready   (instr_ready),
    .instr_valid   (instr_valid),
    .instr_bits    (instr_bits),
    .instr_pc      (instr_pc),
    .instr_is_load (instr_is_load),
    .fetch_state   (fetch_state)
  );

  function automatic logic ref_is_load(input logic [31:0] w);
    return w[6:0] == 7'b0000011;
  endfunction

  task automatic next_cycle();
    @(negedge clock);
    cyc++;
  endtask

  // Reset is high during cycle 0; cycle 1 is the first cycle out of reset.
  task automatic reset_dut(input logic ready);
    @(negedge clock);
    reset       = 1'b1;
    mem_grant   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = ready;
    @(negedge clock);
    reset = 1'b0;
    cyc   = 1;
  endtask

  task automatic test_reset();
    reset_dut(1'b0);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (fetch_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", fetch_state, IDLE); end
    checks++; if (mem_ctrl.wenable !== 1'b0) begin failures++; $display("FAIL reset_wenable got=%b exp=0", mem_ctrl.wenable); end
    while (cyc < 10) begin
      next_cycle();
      checks++; if (instr_valid !== (cyc >= 4)) begin failures++; $display("FAIL fill_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, (cyc >= 4)); end
      if (cyc == 4) begin
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL first_pc got=%h exp=0", instr_pc); end
        checks++; if (instr_bits !== 32'h00500093) begin failures++; $display("FAIL first_bits got=%h exp=00500093", instr_bits); end
        checks++; if (instr_is_load !== 1'b0) begin failures++; $display("FAIL first_is_load got=%b exp=0", instr_is_load); end
      end
      if (cyc >= 7) begin
        checks++; if (fetch_state !== IDLE) begin failures++; $display("FAIL full_no_read cyc=%0d got=%0d exp=%0d", cyc, fetch_state, IDLE); end
      end
    end
    instr_ready = 1'b1;
    next_cycle();
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin failures++; $display("FAIL second_entry got=%b/%h exp=1/00000004", instr_valid, instr_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] w;
    logic [31:0] exp_pc;
    logic        exp_pop, got_pop;
    mem[0] = 32'h00500093;
    w = $urandom(); w[6:0] = 7'h13; mem[1] = w;
    mem[2] = 32'h00412183;
    w = $urandom(); w[6:0] = 7'h33; mem[3] = w;
    exp_q = {32'h0, 32'h4, 32'h8, 32'hc};
    reset_dut(1'b1);
    while (cyc < 16) begin
      exp_pop = (cyc == 4 || cyc == 7 || cyc == 10 || cyc == 13);
      got_pop = instr_valid && instr_ready;
      checks++; if (got_pop !== exp_pop) begin failures++; $display("FAIL stream_pop cyc=%0d got=%b exp=%b", cyc, got_pop, exp_pop); end
      if (got_pop && exp_q.size() > 0) begin
        exp_pc = exp_q.pop_front();
        checks++; if (instr_pc !== exp_pc) begin failures++; $display("FAIL stream_pc got=%h exp=%h", instr_pc, exp_pc); end
        checks++; if (instr_bits !== mem[exp_pc[9:2]]) begin failures++; $display("FAIL stream_bits got=%h exp=%h", instr_bits, mem[exp_pc[9:2]]); end
        checks++; if (instr_is_load !== ref_is_load(mem[exp_pc[9:2]])) begin failures++; $display("FAIL stream_is_load pc=%h got=%b exp=%b", exp_pc, instr_is_load, ref_is_load(mem[exp_pc[9:2]])); end
      end
      next_cycle();
    end
    instr_ready = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stream_missing got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    reset_dut(1'b0);
    while (cyc < 13) begin
      instr_ready = (cyc == 4);
      redirect    = (cyc == 8);
      redirect_pc = (cyc == 8) ? 32'h00000102 : 32'h0;
      if (cyc == 7) begin
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin failures++; $display("FAIL redir_pre got=%b/%h exp=1/00000004", instr_valid, instr_pc); end
      end
      if (cyc == 8) begin
        checks++; if (fetch_state !== READ || mem_ctrl.addr !== 32'h8) begin failures++; $display("FAIL redir_inflight got=%0d/%h exp=%0d/00000008", fetch_state, mem_ctrl.addr, READ); end
      end
      if (cyc >= 9 && cyc <= 11) begin
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_flush cyc=%0d got=%b exp=0", cyc, instr_valid); end
        checks++; if (mem_ctrl.addr !== 32'h100) begin failures++; $display("FAIL redir_addr cyc=%0d got=%h exp=00000100", cyc, mem_ctrl.addr); end
      end
      if (cyc == 12) begin
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin failures++; $display("FAIL redir_target got=%b/%h exp=1/00000100", instr_valid, instr_pc); end
        checks++; if (instr_bits !== mem[64]) begin failures++; $display("FAIL redir_bits got=%h exp=%h", instr_bits, mem[64]); end
      end
      next_cycle();
    end
    redirect    = 1'b0;
    instr_ready = 1'b0;
  endtask

  task automatic test_grant_drop();
    logic [31:0] exp_pc;
    logic        exp_pop, got_pop;
    exp_q = {32'h0, 32'h4, 32'h8};
    reset_dut(1'b1);
    while (cyc < 16) begin
      mem_grant = !(cyc >= 5 && cyc <= 7);
      exp_pop = (cyc == 4 || cyc == 11 || cyc == 14);
      got_pop = instr_valid && instr_ready;
      checks++; if (got_pop !== exp_pop) begin failures++; $display("FAIL grant_pop cyc=%0d got=%b exp=%b", cyc, got_pop, exp_pop); end
      if (got_pop && exp_q.size() > 0) begin
        exp_pc = exp_q.pop_front();
        checks++; if (instr_pc !== exp_pc) begin failures++; $display("FAIL grant_pc got=%h exp=%h", instr_pc, exp_pc); end
        checks++; if (instr_bits !== mem[exp_pc[9:2]]) begin failures++; $display("FAIL grant_bits got=%h exp=%h", instr_bits, mem[exp_pc[9:2]]); end
      end
      next_cycle();
    end
    mem_grant   = 1'b1;
    instr_ready = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL grant_missing got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    reset_dut(1'b0);
    while (cyc < 15) begin
      instr_ready = (cyc == 7);
      reset       = (cyc == 10);
      if (cyc == 7) begin
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b exp=1", instr_valid); end
      end
      if (cyc == 10) begin
        checks++; if (fetch_state !== READ) begin failures++; $display("FAIL midrst_inflight got=%0d exp=%0d", fetch_state, READ); end
      end
      if (cyc == 11) begin
        checks++; if (fetch_state !== IDLE || mem_ctrl.addr !== 32'h0) begin failures++; $display("FAIL midrst_restart got=%0d/%h exp=%0d/00000000", fetch_state, mem_ctrl.addr, IDLE); end
      end
      if (cyc >= 11 && cyc <= 13) begin
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL midrst_empty cyc=%0d got=%b exp=0", cyc, instr_valid); end
      end
      if (cyc == 14) begin
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_bits !== mem[0]) begin failures++; $display("FAIL midrst_first got=%b/%h/%h exp=1/00000000/%h", instr_valid, instr_pc, instr_bits, mem[0]); end
      end
      next_cycle();
    end
    reset       = 1'b0;
    instr_ready = 1'b0;
  endtask

  // Reference: decode sees consecutive word addresses, restarting at each
  // redirect target; every word matches memory and its load pre-decode.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic        prev_redir;
    int          pops;
    exp_pc     = 32'h0;
    prev_redir = 1'b0;
    pops       = 0;
    reset_dut(1'b0);
    for (int n = 0; n < 1500; n++) begin
      if (prev_redir) begin
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rand_flush n=%0d got=%b exp=0", n, instr_valid); end
      end
      mem_grant   = ($urandom_range(0, 9) != 0);
      instr_ready = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = 32'($urandom_range(0, 1023));
      if (instr_valid && instr_ready && !redirect) begin
        checks++; if (instr_pc !== exp_pc) begin failures++; $display("FAIL rand_pc n=%0d got=%h exp=%h", n, instr_pc, exp_pc); end
        checks++; if (instr_bits !== mem[exp_pc[9:2]]) begin failures++; $display("FAIL rand_bits n=%0d got=%h exp=%h", n, instr_bits, mem[exp_pc[9:2]]); end
        checks++; if (instr_is_load !== ref_is_load(mem[exp_pc[9:2]])) begin failures++; $display("FAIL rand_is_load n=%0d got=%b exp=%b", n, instr_is_load, ref_is_load(mem[exp_pc[9:2]])); end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (redirect) exp_pc = redirect_pc & ~32'd3;
      prev_redir = redirect;
      next_cycle();
    end
    redirect    = 1'b0;
    instr_ready = 1'b0;
    checks++; if (pops < 100) begin failures++; $display("FAIL rand_progress got=%0d exp>=100", pops); end
  endtask

  initial begin
    logic [31:0] w;
    reset       = 1'b1;
    mem_grant   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom();
      if ($urandom_range(0, 3) == 0) w[6:0] = 7'b0000011;
      mem[i] = w;
    end
    mem[0] = 32'h00500093;
    test_reset();
    test_stream();
    test_redirect();
    test_grant_drop();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
